ber_checker: RTL and testbench
==============================

Name: ber_checker

Overview:
- Sits directly downstream of rx and consumes its recovered bit stream.
- Aligns the received stream against the local PRBS9 reference bit from the prbs9 instance by searching every candidate delay.
- Once aligned, locks and continuously accumulates bit and error counts for BER measurement.
- Runs on the same 1-in-4 strobe enable that drives prbs9.

Parameters:
- DELAY_LEN, 512, number of candidate delays; searched delays are 0..DELAY_LEN-1.
- WINDOW, 511, strobes accumulated per candidate during search (one PRBS9 period).
- CNT_W, 64, width of the bit and error counters.
- RESYNC_THR, 64, window error count that triggers a resync (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  symbol strobe; all state advances only when it is 1.
- i_ref  in  1  reference bit from prbs9.
- i_rx  in  1  received bit from rx.
- i_clear  in  1  synchronous clear of the counters; lock is kept.
- i_resync  in  1  synchronous request to drop lock and restart the search.
- o_locked  out  1  1 while in LOCKED.
- o_delay  out  clog2(DELAY_LEN)  chosen delay.
- o_bit_count  out  CNT_W  bits compared while locked.
- o_err_count  out  CNT_W  mismatches while locked.

Behaviour:
- History:
  - A shift register holds DELAY_LEN-1 past i_ref bits.
  - hist[0] = current i_ref; hist[k] = i_ref sampled k strobes earlier.
  - The shift register shifts in i_ref on every enable, in any state.
  - The compare at a strobe uses hist before that strobe's shift.
  - Hence i_rx(n) = i_ref(n-d) aligns at delay d.
- Reset (asynchronous) values:
  - state=SEARCH, cand=0, win_cnt=0, win_err=0, best_err=all ones, best_delay=0.
  - o_locked=0, o_delay=0, counters 0, shift register 0.
- enable=0: all state holds, including the shift register. Inputs i_clear and i_resync are still honoured.
- SEARCH, on each enable:
  - win_err += (i_rx != hist[cand]); win_cnt++.
  - When win_cnt reaches WINDOW (final increment), the window closes on that strobe's sample, including its error:
    - If the final win_err < best_err (strict), set best_err = win_err and best_delay = cand.
    - Ties keep the lowest delay.
    - Clear win_cnt and win_err; cand++.
  - After closing cand = DELAY_LEN-1:
    - Next state is LOCKED; o_delay = best_delay (final compare included).
    - o_locked asserts 1 clock after that strobe.
    - cand, best_err and best_delay re-initialise.
  - Search latency: DELAY_LEN*WINDOW strobes.
- LOCKED, on each enable:
  - o_bit_count++; o_err_count += (i_rx != hist[o_delay]).
  - Both counters saturate at all ones and never wrap.
  - o_delay is stable while locked.
- i_clear=1:
  - Counters go to 0 on the next clock.
  - If enable is 1 in the same cycle, clear wins and that sample is not counted.
  - State and lock are unaffected.
- i_resync=1:
  - Next clock: state=SEARCH, o_locked=0, search registers re-initialised, counters cleared.
  - o_delay keeps its last value.
  - Takes priority over i_clear and over a simultaneous lock transition.
- Counters do not change while in SEARCH.

Optional Feature:
- Macro: BER_AUTO_RESYNC_EN.
- When defined:
  - LOCKED also runs a WINDOW-strobe error window.
  - When a window closes with error count > RESYNC_THR, the block behaves exactly as if i_resync had been pulsed.
  - Equality with RESYNC_THR does not resync.
- When undefined:
  - No window logic is present; lock is held until i_resync or rst.

Decomposition:
- Shared package:
  - state encoding (SEARCH, LOCKED);
  - function for the delay-index width, clog2(DELAY_LEN);
  - default constants for DELAY_LEN, WINDOW and the PRBS9 period (511).
- One natural sub-module: ber_sat_counter, a saturating CNT_W accumulator with clear and increment-by-0/1, instanced for both counters.

Test Plan:
- i_rx = i_ref delayed by 37 strobes, no errors -> o_locked=1 after 512*511 strobes, o_delay=37; after 10000 further strobes, bit_count=10000 and err_count=0.
- Same setup but i_rx inverted on every 100th strobe after lock -> err_count=100 after 10000 strobes, ±0 exact.
- i_clear pulsed coincident with enable while locked -> both counters read 0 next cycle; that strobe's sample is not counted; o_locked stays 1.
- Set CNT_W=4, lock, then drive constant errors -> err_count sticks at 15 and does not wrap.
- i_resync while locked -> o_locked=0 next clock; relock at a new delay of 5 after the full search. rst asserted mid-search -> all outputs 0 immediately.
- With BER_AUTO_RESYNC_EN: after lock, invert i_rx -> o_locked drops at the end of the first window; with error count exactly RESYNC_THR, lock is held.

Source files
------------

// File: rtl/ber_checker_pkg.sv
// Shared definitions for the PRBS9 bit-error-rate checker: FSM encoding,
// default sizing constants and index-width helpers.
package ber_checker_pkg;

  localparam int PRBS9_PERIOD   = 511;
  localparam int DEF_DELAY_LEN  = 512;
  localparam int DEF_WINDOW     = PRBS9_PERIOD;
  localparam int DEF_CNT_W      = 64;
  localparam int DEF_RESYNC_THR = 64;

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Width of a delay index; never narrower than one bit.
  function automatic int delay_idx_w(input int delay_len);
    return (delay_len > 1) ? $clog2(delay_len) : 1;
  endfunction

  // Width able to hold a window count or a window error total (0..window).
  function automatic int win_cnt_w(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/ber_sat_counter.sv
// Saturating accumulator: synchronous clear has priority, otherwise adds 0 or 1
// and sticks at all ones instead of wrapping.
module ber_sat_counter
  import ber_checker_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/ber_checker.sv
// PRBS9 BER checker: searches every candidate delay of the local reference,
// locks on the best one and accumulates bit/error counts.
// Optional macro BER_AUTO_RESYNC_EN adds a locked-state error window that
// drops lock when a window's error total exceeds RESYNC_THR.
module ber_checker
  import ber_checker_pkg::*;
#(
  parameter int  DELAY_LEN  = DEF_DELAY_LEN,
  parameter int  WINDOW     = DEF_WINDOW,
  parameter int  CNT_W      = DEF_CNT_W,
  parameter int  RESYNC_THR = DEF_RESYNC_THR,
  localparam int DW         = delay_idx_w(DELAY_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             i_ref,
  input  logic             i_rx,
  input  logic             i_clear,
  input  logic             i_resync,
  output logic             o_locked,
  output logic [DW-1:0]    o_delay,
  output logic [CNT_W-1:0] o_bit_count,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int             WW        = win_cnt_w(WINDOW);
  localparam logic [DW-1:0]  CAND_LAST = DW'(DELAY_LEN - 1);
  localparam logic [WW-1:0]  WIN_LAST  = WW'(WINDOW - 1);

  if (DELAY_LEN < 2 || WINDOW < 1 || CNT_W < 1 || RESYNC_THR < 0) begin : g_bad_params
    $error("ber_checker: unsupported parameter set");
  end

  logic [0:0]           state_q, state_d;
  logic [DW-1:0]        cand_q, cand_d;
  logic [DW-1:0]        best_delay_q, best_delay_d;
  logic [DW-1:0]        delay_q, delay_d;
  logic [WW-1:0]        win_cnt_q, win_cnt_d;
  logic [WW-1:0]        win_err_q, win_err_d;
  logic [WW-1:0]        best_err_q, best_err_d;
  logic [DELAY_LEN-2:0] hist_q, hist_d;

  logic [DELAY_LEN-1:0] hist_full;
  logic [WW-1:0]        win_err_sum;
  logic                 search_miss;
  logic                 lock_miss;
  logic                 new_best;
  logic                 win_close;
  logic                 auto_resync;
  logic                 resync_req;
  logic                 count_en;

  // Bit 0 is the live reference, so a delay of 0 compares against i_ref itself.
  assign hist_full   = {hist_q, i_ref};
  assign search_miss = i_rx ^ hist_full[cand_q];
  assign lock_miss   = i_rx ^ hist_full[delay_q];
  assign win_err_sum = win_err_q + WW'(search_miss);
  assign new_best    = (win_err_sum < best_err_q);
  assign win_close   = (win_cnt_q == WIN_LAST);
  assign resync_req  = i_resync | auto_resync;
  assign count_en    = enable && (state_q == ST_LOCKED) && !resync_req;

  always_comb begin
    hist_d = hist_q;
    if (enable) begin
      hist_d = hist_full[DELAY_LEN-2:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    best_delay_d = best_delay_q;
    delay_d      = delay_q;
    win_cnt_d    = win_cnt_q;
    win_err_d    = win_err_q;
    best_err_d   = best_err_q;

    if (resync_req) begin
      state_d      = ST_SEARCH;
      cand_d       = '0;
      win_cnt_d    = '0;
      win_err_d    = '0;
      best_err_d   = '1;
      best_delay_d = '0;
    end else if (enable && (state_q == ST_SEARCH)) begin
      if (win_close) begin
        win_cnt_d = '0;
        win_err_d = '0;
        // Strict compare with ascending candidates keeps the lowest delay on ties.
        if (cand_q == CAND_LAST) begin
          state_d      = ST_LOCKED;
          delay_d      = new_best ? cand_q : best_delay_q;
          cand_d       = '0;
          best_err_d   = '1;
          best_delay_d = '0;
        end else begin
          cand_d = cand_q + DW'(1);
          if (new_best) begin
            best_err_d   = win_err_sum;
            best_delay_d = cand_q;
          end
        end
      end else begin
        win_cnt_d = win_cnt_q + WW'(1);
        win_err_d = win_err_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SEARCH;
      cand_q       <= '0;
      best_delay_q <= '0;
      delay_q      <= '0;
      win_cnt_q    <= '0;
      win_err_q    <= '0;
      best_err_q   <= '1;
      hist_q       <= '0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      best_delay_q <= best_delay_d;
      delay_q      <= delay_d;
      win_cnt_q    <= win_cnt_d;
      win_err_q    <= win_err_d;
      best_err_q   <= best_err_d;
      hist_q       <= hist_d;
    end
  end

`ifdef BER_AUTO_RESYNC_EN
  logic [WW-1:0] lwin_cnt_q, lwin_cnt_d;
  logic [WW-1:0] lwin_err_q, lwin_err_d;
  logic [WW-1:0] lwin_err_sum;

  assign lwin_err_sum = lwin_err_q + WW'(lock_miss);
  // Combinational so lock drops on the very clock that closes the bad window.
  assign auto_resync  = enable && (state_q == ST_LOCKED) && (lwin_cnt_q == WIN_LAST)
                        && (int'(lwin_err_sum) > RESYNC_THR);

  always_comb begin
    lwin_cnt_d = lwin_cnt_q;
    lwin_err_d = lwin_err_q;
    if (i_resync || (state_q != ST_LOCKED)) begin
      lwin_cnt_d = '0;
      lwin_err_d = '0;
    end else if (enable) begin
      if (lwin_cnt_q == WIN_LAST) begin
        lwin_cnt_d = '0;
        lwin_err_d = '0;
      end else begin
        lwin_cnt_d = lwin_cnt_q + WW'(1);
        lwin_err_d = lwin_err_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lwin_cnt_q <= '0;
      lwin_err_q <= '0;
    end else begin
      lwin_cnt_q <= lwin_cnt_d;
      lwin_err_q <= lwin_err_d;
    end
  end
`else
  assign auto_resync = 1'b0;
`endif

  ber_sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (i_clear | resync_req),
    .inc     (count_en),
    .o_count (o_bit_count)
  );

  ber_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (i_clear | resync_req),
    .inc     (count_en & lock_miss),
    .o_count (o_err_count)
  );

  assign o_locked = (state_q == ST_LOCKED);
  assign o_delay  = delay_q;

endmodule

// File: tb/tb_ber_checker.sv
// Self-checking bench for ber_checker: a PRBS9 source, a delayed/corrupted rx
// stream, and a queue-based model that picks the best delay and tallies counts.
module tb_ber_checker;

  localparam int DL             = 64;
  localparam int WIN            = 63;
  localparam int THR            = 10;
  localparam int SEARCH_STROBES = DL * WIN;
  localparam int GUARD          = 8 * SEARCH_STROBES;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        i_ref = 1'b0;
  logic        i_rx = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_resync = 1'b0;
  logic        o_locked, s_locked;
  logic [5:0]  o_delay, s_delay;
  logic [63:0] o_bit_count, o_err_count;
  logic [3:0]  s_bit_count, s_err_count;

  int     tests = 0;
  int     fails = 0;
  bit     ref_q[$];
  bit     rx_q[$];
  logic [8:0] lfsr = 9'h1FF;
  int     rx_delay = 37;
  bit     m_locked = 1'b0;
  int     m_delay = 0;
  longint exp_bits = 0;
  longint exp_errs = 0;

  always #5 clk = ~clk;

  ber_checker #(.DELAY_LEN(DL), .WINDOW(WIN), .CNT_W(64), .RESYNC_THR(THR)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .i_ref(i_ref), .i_rx(i_rx),
    .i_clear(i_clear), .i_resync(i_resync), .o_locked(o_locked), .o_delay(o_delay),
    .o_bit_count(o_bit_count), .o_err_count(o_err_count)
  );

  ber_checker #(.DELAY_LEN(DL), .WINDOW(WIN), .CNT_W(4), .RESYNC_THR(THR)) u_small (
    .clk(clk), .rst(rst), .enable(enable), .i_ref(i_ref), .i_rx(i_rx),
    .i_clear(i_clear), .i_resync(i_resync), .o_locked(s_locked), .o_delay(s_delay),
    .o_bit_count(s_bit_count), .o_err_count(s_err_count)
  );

  function automatic bit ref_at(input int idx);
    if (idx < 0) return 1'b0;
    return ref_q[idx];
  endfunction

  function automatic logic [3:0] sat4(input longint v);
    return (v > 15) ? 4'hF : 4'(v);
  endfunction

  // One clock: drive at the falling edge, DUT samples at the rising edge,
  // return at the next falling edge where outputs are observed.
  task automatic strobe(input bit en, input bit inv, input bit clr, input bit rsy);
    int n;
    bit r;
    bit x;
    enable   = en;
    i_clear  = clr;
    i_resync = rsy;
    if (clr || rsy) begin
      exp_bits = 0;
      exp_errs = 0;
    end
    if (rsy) m_locked = 1'b0;
    if (en) begin
      n = ref_q.size();
      r = lfsr[8];
      lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
      ref_q.push_back(r);
      x = ref_at(n - rx_delay) ^ inv;
      rx_q.push_back(x);
      i_ref = r;
      i_rx  = x;
      if (m_locked && !clr && !rsy) begin
        exp_bits++;
        if (x != ref_at(n - m_delay)) exp_errs++;
      end
    end else begin
      i_ref = 1'($urandom);
      i_rx  = 1'($urandom);
    end
    @(posedge clk);
    @(negedge clk);
    i_clear  = 1'b0;
    i_resync = 1'b0;
  endtask

  task automatic run_strobes(input int count, input int inv_every);
    bit inv;
    for (int k = 0; k < count; k++) begin
      while ($urandom_range(0, 3) == 0) strobe(1'b0, 1'b0, 1'b0, 1'b0);
      inv = (inv_every > 0) && ((k % inv_every) == (inv_every - 1));
      strobe(1'b1, inv, 1'b0, 1'b0);
    end
  endtask

  task automatic search_and_lock(input string tag);
    int s0, guard, best, best_e, e, n;
    s0 = ref_q.size();
    guard = 0;
    while (((ref_q.size() - s0) < SEARCH_STROBES - 1) && (guard < GUARD)) begin
      strobe(($urandom_range(0, 3) != 0), 1'b0, 1'b0, 1'b0);
      guard++;
    end
    tests++;
    if (guard >= GUARD || o_locked !== 1'b0) begin
      fails++;
      $display("FAIL %s_early_lock: o_locked=%0b guard=%0d required locked=0 within budget", tag, o_locked, guard);
      return;
    end
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    best = 0;
    best_e = WIN + 1;
    for (int c = 0; c < DL; c++) begin
      e = 0;
      for (int k = 0; k < WIN; k++) begin
        n = s0 + c * WIN + k;
        if (rx_q[n] != ref_at(n - c)) e++;
      end
      if (e < best_e) begin
        best_e = e;
        best = c;
      end
    end
    tests++;
    if (o_locked !== 1'b1 || s_locked !== 1'b1) begin
      fails++;
      $display("FAIL %s_lock: o_locked=%0b s_locked=%0b required 1", tag, o_locked, s_locked);
    end
    tests++;
    if (o_delay !== 6'(best)) begin
      fails++;
      $display("FAIL %s_delay_model: got %0d expected %0d", tag, o_delay, best);
    end
    tests++;
    if (o_delay !== 6'(rx_delay) || s_delay !== 6'(rx_delay)) begin
      fails++;
      $display("FAIL %s_delay: got %0d/%0d expected %0d", tag, o_delay, s_delay, rx_delay);
    end
    m_locked = 1'b1;
    m_delay  = best;
    exp_bits = 0;
    exp_errs = 0;
    $display("[TB] %s: locked at delay %0d after %0d strobes", tag, o_delay, ref_q.size() - s0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (o_locked !== 1'b0 || o_delay !== 6'd0 || o_bit_count !== 64'd0 || o_err_count !== 64'd0) begin
      fails++;
      $display("FAIL reset_state: locked=%0b delay=%0d bits=%0d errs=%0d required all 0",
               o_locked, o_delay, o_bit_count, o_err_count);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] test_reset done");
  endtask

  task automatic test_search_lock();
    rx_delay = 37;
    search_and_lock("search37");
  endtask

  task automatic test_clean_count();
    run_strobes(10000, 0);
    tests++;
    if (o_bit_count !== 64'(exp_bits) || o_bit_count !== 64'd10000) begin
      fails++;
      $display("FAIL clean_bits: got %0d expected %0d", o_bit_count, exp_bits);
    end
    tests++;
    if (o_err_count !== 64'(exp_errs) || o_err_count !== 64'd0) begin
      fails++;
      $display("FAIL clean_errs: got %0d expected %0d", o_err_count, exp_errs);
    end
    tests++;
    if (s_bit_count !== sat4(exp_bits) || s_err_count !== sat4(exp_errs)) begin
      fails++;
      $display("FAIL clean_small: bits=%0d errs=%0d expected %0d/%0d",
               s_bit_count, s_err_count, sat4(exp_bits), sat4(exp_errs));
    end
    $display("[TB] test_clean_count: bits=%0d errs=%0d", o_bit_count, o_err_count);
  endtask

  task automatic test_clear();
    strobe(1'b1, 1'b1, 1'b1, 1'b0);
    tests++;
    if (o_bit_count !== 64'd0 || o_err_count !== 64'd0 || s_bit_count !== 4'd0 || s_err_count !== 4'd0) begin
      fails++;
      $display("FAIL clear_counts: bits=%0d errs=%0d small=%0d/%0d required 0",
               o_bit_count, o_err_count, s_bit_count, s_err_count);
    end
    tests++;
    if (o_locked !== 1'b1) begin
      fails++;
      $display("FAIL clear_lock: o_locked=%0b required 1", o_locked);
    end
    strobe(1'b1, 1'b1, 1'b0, 1'b0);
    tests++;
    if (o_bit_count !== 64'(exp_bits) || o_err_count !== 64'(exp_errs)) begin
      fails++;
      $display("FAIL clear_after: bits=%0d errs=%0d expected %0d/%0d",
               o_bit_count, o_err_count, exp_bits, exp_errs);
    end
    $display("[TB] test_clear done");
  endtask

  task automatic test_sparse_errors();
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    run_strobes(10000, 100);
    tests++;
    if (o_err_count !== 64'(exp_errs) || o_err_count !== 64'd100) begin
      fails++;
      $display("FAIL sparse_errs: got %0d expected %0d", o_err_count, exp_errs);
    end
    tests++;
    if (o_bit_count !== 64'(exp_bits) || o_bit_count !== 64'd10000) begin
      fails++;
      $display("FAIL sparse_bits: got %0d expected %0d", o_bit_count, exp_bits);
    end
    $display("[TB] test_sparse_errors: bits=%0d errs=%0d", o_bit_count, o_err_count);
  endtask

  task automatic test_resync();
    rx_delay = 5;
    strobe(1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (o_locked !== 1'b0 || o_bit_count !== 64'd0 || o_err_count !== 64'd0) begin
      fails++;
      $display("FAIL resync_drop: locked=%0b bits=%0d errs=%0d required 0", o_locked, o_bit_count, o_err_count);
    end
    tests++;
    if (o_delay !== 6'd37) begin
      fails++;
      $display("FAIL resync_delay_kept: got %0d expected 37", o_delay);
    end
    search_and_lock("resync5");
  endtask

  task automatic test_saturation();
    run_strobes(40, 1);
    tests++;
    if (s_err_count !== sat4(exp_errs) || s_err_count !== 4'hF) begin
      fails++;
      $display("FAIL sat_small_errs: got %0d expected %0d", s_err_count, sat4(exp_errs));
    end
    tests++;
    if (s_bit_count !== 4'hF) begin
      fails++;
      $display("FAIL sat_small_bits: got %0d expected 15", s_bit_count);
    end
    tests++;
    if (o_err_count !== 64'(exp_errs) || o_bit_count !== 64'(exp_bits)) begin
      fails++;
      $display("FAIL sat_main: bits=%0d errs=%0d expected %0d/%0d", o_bit_count, o_err_count, exp_bits, exp_errs);
    end
    $display("[TB] test_saturation: small errs=%0d main errs=%0d", s_err_count, o_err_count);
  endtask

  task automatic test_reset_midsearch();
    strobe(1'b0, 1'b0, 1'b0, 1'b1);
    run_strobes(1000, 0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (o_locked !== 1'b0 || o_delay !== 6'd0 || o_bit_count !== 64'd0 || o_err_count !== 64'd0
        || s_delay !== 6'd0) begin
      fails++;
      $display("FAIL async_reset: locked=%0b delay=%0d bits=%0d errs=%0d required all 0",
               o_locked, o_delay, o_bit_count, o_err_count);
    end
    ref_q.delete();
    rx_q.delete();
    m_locked = 1'b0;
    exp_bits = 0;
    exp_errs = 0;
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] test_reset_midsearch done");
    search_and_lock("after_rst");
  endtask

`ifdef BER_AUTO_RESYNC_EN
  task automatic test_auto_resync();
    for (int k = 0; k < WIN; k++) strobe(1'b1, (k < THR), 1'b0, 1'b0);
    tests++;
    if (o_locked !== 1'b1) begin
      fails++;
      $display("FAIL auto_thr_equal: o_locked=%0b required 1", o_locked);
    end
    for (int k = 0; k < WIN - 1; k++) strobe(1'b1, 1'b1, 1'b0, 1'b0);
    tests++;
    if (o_locked !== 1'b1) begin
      fails++;
      $display("FAIL auto_before_close: o_locked=%0b required 1", o_locked);
    end
    strobe(1'b1, 1'b1, 1'b0, 1'b0);
    m_locked = 1'b0;
    tests++;
    if (o_locked !== 1'b0 || o_bit_count !== 64'd0) begin
      fails++;
      $display("FAIL auto_drop: o_locked=%0b bits=%0d required 0/0", o_locked, o_bit_count);
    end
    $display("[TB] test_auto_resync done");
  endtask
`endif

  initial begin
    test_reset();
    test_search_lock();
    test_clean_count();
    test_clear();
    test_sparse_errors();
    test_resync();
    test_saturation();
    test_reset_midsearch();
`ifdef BER_AUTO_RESYNC_EN
    test_auto_resync();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
